if_id_stage: RTL
================

# if_id_stage

Pipeline register between the fetch stage and decode. Each cycle it captures the instruction byte, the immediate byte and the PC of the instruction just fetched, and tells fetch whether the current instruction is a two-byte instruction. It handles stall (hold), flush on a taken branch (bubble), and interrupt entry: it injects one synthetic interrupt instruction carrying the return PC, then emits bubbles until the interrupt request drops.

## Interface
- IMM_OPCODE, 4'hC: upper-nibble opcode of two-byte (immediate-carrying) instructions.
- NOP_INSTR, 8'h00: instruction byte presented for a bubble.
- INTR_INSTR, 8'hF8: synthetic instruction byte injected on interrupt entry.
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- instruction  input  8  memory byte at pc.
- immediate  input  8  memory byte at pc+1.
- pc  input  8  current fetch PC.
- f_stall  input  1  hold the IF/ID contents (decode not accepting).
- branch_taken  input  1  flush: the fetched instruction is on the wrong path.
- intr_active  input  1  interrupt in service; high for the whole entry sequence.
- immediate_enabled  output  1  combinational: instruction[7:4] == IMM_OPCODE; fetch uses it to step pc by 2.
- id_valid  output  1  the registered slot holds a real instruction.
- id_instruction  output  8  registered instruction byte.
- id_immediate  output  8  registered immediate byte; 8'h00 when not a two-byte instruction.
- id_pc  output  8  PC of the registered instruction, or return PC for INTR_INSTR.
- id_pc_next  output  8  id_pc+1, or id_pc+2 for a two-byte instruction; mod 256.

## Operation
- FSM states:
  - RUN: normal operation.
  - INJ: one cycle; captures INTR_INSTR.
  - WAIT: bubbles until intr_active deasserts.
- Priority each cycle: reset > branch_taken > interrupt handling > f_stall > capture.
- reset: state=RUN, id_valid=0, id_instruction=NOP_INSTR, id_immediate=0, id_pc=0, id_pc_next=0.
- branch_taken (any state): load a bubble (id_valid=0, id_instruction=NOP_INSTR, id_immediate=0, id_pc/id_pc_next unchanged).
  - The FSM still advances per the interrupt rules below; branch_taken during INJ cancels that injection but still moves to WAIT.
- RUN, intr_active=1: capture INTR_INSTR with id_pc=pc (pc is already held by fetch), id_pc_next=pc, id_valid=1, id_immediate=0; go to INJ. f_stall is ignored on this edge.
- INJ: load a bubble; go to WAIT if intr_active=1, else RUN.
- WAIT: load a bubble while intr_active=1; when it is 0, load a bubble and go to RUN.
- RUN, f_stall=1: all outputs hold.
- RUN, capture:
  - id_valid=1, id_instruction=instruction, id_pc=pc.
  - id_immediate=immediate if two-byte, else 0.
  - id_pc_next=pc+2 (two-byte) or pc+1, truncated to 8 bits (8'hFF+1=8'h00, 8'hFF+2=8'h01).
- immediate_enabled is driven from the raw instruction input in every state, including during stall, flush and reset; it has no register.

## Timing
- Latency: one clock from instruction/pc on the input to the id_* outputs.
- Throughput: one instruction per cycle when f_stall=0.
- A stall holds for exactly as many cycles as f_stall is high; the first cycle after f_stall falls captures the current input.
- Interrupt entry: INTR_INSTR is visible for exactly one cycle, on the edge after intr_active rises in RUN. Bubbles follow until the cycle after intr_active falls. The first real instruction is captured on the following edge.
- Reset in mid-sequence (INJ/WAIT) returns to RUN with the reset values on the next edge.

## Test plan
- Reset then stream: pc=0x10, instruction=0x23 → next edge: id_valid=1, id_instruction=0x23, id_pc=0x10, id_pc_next=0x11, id_immediate=0, and immediate_enabled=0 throughout.
- Two-byte capture: pc=0xFF, instruction=0xC5, immediate=0x7A → immediate_enabled=1 combinationally; next edge: id_immediate=0x7A, id_pc_next=0x01.
- Stall: capture 0x31 at 0x04, then f_stall high for 3 cycles with changing inputs → outputs frozen at 0x31/0x04; the cycle after release captures the live input.
- Flush with stall: branch_taken=1 and f_stall=1 together → id_valid=0, id_instruction=0x00, id_pc unchanged.
- Interrupt: intr_active high for 4 cycles at pc=0x20 → one cycle id_instruction=0xF8, id_pc=0x20, id_valid=1, then bubbles; the first real instruction appears two edges after intr_active falls.
- Interrupt interrupted: branch_taken during INJ → bubble and state WAIT. Reset during WAIT → state RUN, id_valid=0, id_pc=0.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bus: raw fetch inputs, the two-byte hint back to fetch, and the IF/ID slot.
// master drives fetch-side signals; slave is the pipeline register.
interface if_id_stage_if;
   logic [7:0] instruction;
   logic [7:0] immediate;
   logic [7:0] pc;
   logic       f_stall;
   logic       branch_taken;
   logic       intr_active;
   logic       immediate_enabled;
   logic       id_valid;
   logic [7:0] id_instruction;
   logic [7:0] id_immediate;
   logic [7:0] id_pc;
   logic [7:0] id_pc_next;

   modport master (
      output instruction, immediate, pc, f_stall, branch_taken, intr_active,
      input  immediate_enabled, id_valid, id_instruction, id_immediate, id_pc, id_pc_next
   );

   modport slave (
      input  instruction, immediate, pc, f_stall, branch_taken, intr_active,
      output immediate_enabled, id_valid, id_instruction, id_immediate, id_pc, id_pc_next
   );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall, branch flush and interrupt-entry injection.
// One synthetic interrupt instruction carries the return PC, then bubbles until the request drops.
module if_id_stage #(
   parameter logic [3:0] IMM_OPCODE = 4'hC,
   parameter logic [7:0] NOP_INSTR  = 8'h00,
   parameter logic [7:0] INTR_INSTR = 8'hF8
) (
   input logic          clk,
   input logic          reset,
   if_id_stage_if.slave bus
);
   typedef enum logic [1:0] {StRun, StInj, StWait} state_e;

   state_e     state_q, state_d;
   logic       valid_q, valid_d;
   logic [7:0] instr_q, instr_d;
   logic [7:0] imm_q, imm_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] pc_next_q, pc_next_d;
   logic       two_byte;

   assign two_byte = (bus.instruction[7:4] == IMM_OPCODE);

   // Interrupt sequencing advances regardless of flush or stall.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:         if (bus.intr_active) state_d = StInj;
         StInj, StWait: state_d = bus.intr_active ? StWait : StRun;
         default:       state_d = StRun;
      endcase
   end

   always_comb begin
      valid_d   = valid_q;
      instr_d   = instr_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      pc_next_d = pc_next_q;
      if (bus.branch_taken || state_q != StRun) begin
         // Bubble: PC fields keep their last values.
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         imm_d   = 8'h00;
      end else if (bus.intr_active) begin
         valid_d   = 1'b1;
         instr_d   = INTR_INSTR;
         imm_d     = 8'h00;
         pc_d      = bus.pc;
         pc_next_d = bus.pc;
      end else if (!bus.f_stall) begin
         valid_d   = 1'b1;
         instr_d   = bus.instruction;
         imm_d     = two_byte ? bus.immediate : 8'h00;
         pc_d      = bus.pc;
         pc_next_d = bus.pc + (two_byte ? 8'd2 : 8'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StRun;
         valid_q   <= 1'b0;
         instr_q   <= NOP_INSTR;
         imm_q     <= 8'h00;
         pc_q      <= 8'h00;
         pc_next_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_next_d;
      end
   end

   assign bus.immediate_enabled = two_byte;
   assign bus.id_valid          = valid_q;
   assign bus.id_instruction    = instr_q;
   assign bus.id_immediate      = imm_q;
   assign bus.id_pc             = pc_q;
   assign bus.id_pc_next        = pc_next_q;
endmodule
